// File: rtl/cu_decod_pipe_if.sv
// Decoded-instruction handshake bundle between vector decoder, decode pipe and issue logic.
// slave = pipe side (consumes *_i, drives *_o); master = the decoder/issue side around it.
interface cu_decod_pipe_if #(
    parameter int NUM_REGS      = 4,
    parameter int MVL           = 16,
    parameter int ADDRESS_WIDTH = 10,
    parameter int DEPTH         = 2
);
    localparam int RW = (NUM_REGS <= 1) ? 1 : $clog2(NUM_REGS);
    localparam int VW = (MVL <= 1) ? 1 : $clog2(MVL);
    localparam int CW = (DEPTH + 1 <= 1) ? 1 : $clog2(DEPTH + 1);

    logic                     flush_i;
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic                     add_i, sub_i, load_i, store_i;
    logic [RW-1:0]            src1_i, src2_i, dst_i;
    logic [ADDRESS_WIDTH-1:0] addr_i;
    logic [VW-1:0]            vector_length_reg_i;

    logic                     out_valid_o;
    logic                     out_ready_i;
    logic                     add_o, sub_o, load_o, store_o;
    logic [RW-1:0]            src1_o, src2_o, dst_o;
    logic [ADDRESS_WIDTH-1:0] addr_o;
    logic [VW-1:0]            vector_length_reg_o;
    logic [CW-1:0]            occupancy_o;
    logic                     illegal_o;

    modport slave (
        input  flush_i, in_valid_i, add_i, sub_i, load_i, store_i,
               src1_i, src2_i, dst_i, addr_i, vector_length_reg_i, out_ready_i,
        output in_ready_o, out_valid_o, add_o, sub_o, load_o, store_o,
               src1_o, src2_o, dst_o, addr_o, vector_length_reg_o, occupancy_o, illegal_o
    );

    modport master (
        output flush_i, in_valid_i, add_i, sub_i, load_i, store_i,
               src1_i, src2_i, dst_i, addr_i, vector_length_reg_i, out_ready_i,
        input  in_ready_o, out_valid_o, add_o, sub_o, load_o, store_o,
               src1_o, src2_o, dst_o, addr_o, vector_length_reg_o, occupancy_o, illegal_o
    );
endinterface

// File: rtl/cu_decod_pipe.sv
// Elastic DEPTH-stage decode pipe with bubble collapse, flush and illegal-opcode drop; latency DEPTH-1 edges.
// Back-pressure: in_ready_o combinationally follows the out_ready_i advance chain, so a full pipe never bubbles.
module cu_decod_pipe #(
    parameter int NUM_REGS      = 4,
    parameter int MVL           = 16,
    parameter int ADDRESS_WIDTH = 10,
    parameter int DEPTH         = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    cu_decod_pipe_if.slave bus
);
    localparam int RW = (NUM_REGS <= 1) ? 1 : $clog2(NUM_REGS);
    localparam int VW = (MVL <= 1) ? 1 : $clog2(MVL);
    localparam int CW = (DEPTH + 1 <= 1) ? 1 : $clog2(DEPTH + 1);

    typedef struct packed {
        logic [3:0]               op;
        logic [RW-1:0]            src1;
        logic [RW-1:0]            src2;
        logic [RW-1:0]            dst;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [VW-1:0]            vl;
    } beat_t;

    beat_t            in_beat;
    beat_t            pay_q   [DEPTH];
    beat_t            pay_src [DEPTH];
    logic [DEPTH-1:0] v_q, v_d, adv, cap;
    logic [CW-1:0]    occ_q, occ_d;
    logic             ill_q, ill_d;
    logic             accept, legal, push;

    assign in_beat = {bus.add_i, bus.sub_i, bus.load_i, bus.store_i,
                      bus.src1_i, bus.src2_i, bus.dst_i, bus.addr_i, bus.vector_length_reg_i};

    // Advance resolves from the output stage backwards so a free slot anywhere ahead lets beats close up.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = v_q[DEPTH-1] & bus.out_ready_i;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
        end
    end

    always_comb begin
        legal = 1'b0;
        case (in_beat.op)
            4'b1000, 4'b0100, 4'b0010, 4'b0001: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
    end

    assign bus.in_ready_o = ~bus.flush_i & (~v_q[0] | adv[0]);
    assign accept         = bus.in_valid_i & bus.in_ready_o;
    assign push           = accept & legal;

    always_comb begin
        pay_src[0] = in_beat;
        cap[0]     = push;
        for (int k = 1; k < DEPTH; k++) begin
            pay_src[k] = pay_q[k-1];
            cap[k]     = adv[k-1] & ~bus.flush_i;
        end
        v_d   = bus.flush_i ? '0 : ((v_q & ~adv) | cap);
        occ_d = bus.flush_i ? '0 : (occ_q + CW'(push) - CW'(adv[DEPTH-1]));
        ill_d = accept & ~legal;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q   <= '0;
            occ_q <= '0;
            ill_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                pay_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            ill_q <= ill_d;
            for (int k = 0; k < DEPTH; k++) begin
                if (cap[k]) begin
                    pay_q[k] <= pay_src[k];
                end
            end
        end
    end

    assign bus.out_valid_o         = v_q[DEPTH-1];
    assign {bus.add_o, bus.sub_o, bus.load_o, bus.store_o} = pay_q[DEPTH-1].op;
    assign bus.src1_o              = pay_q[DEPTH-1].src1;
    assign bus.src2_o              = pay_q[DEPTH-1].src2;
    assign bus.dst_o               = pay_q[DEPTH-1].dst;
    assign bus.addr_o              = pay_q[DEPTH-1].addr;
    assign bus.vector_length_reg_o = pay_q[DEPTH-1].vl;
    assign bus.occupancy_o         = occ_q;
    assign bus.illegal_o           = ill_q;
endmodule

// File: doc/cu_decod_pipe.md
# cu_decod_pipe

Parametrised, elastic successor to the fixed two-stage decode retarder in the vector unit control path. Carries one decoded vector instruction per beat (opcode one-hot, source/destination registers, memory address, vector length) through DEPTH registered stages with valid/ready back-pressure, bubble collapsing, synchronous flush and illegal-opcode filtering. Sits between the vector decoder and the issue/ALU-dispatch logic. With `out_ready_i` tied high and DEPTH=2 it reproduces the old fixed delay.

## Interface
- `NUM_REGS`, 4: vector registers; `RW = bitwidth(NUM_REGS)` (codebase `bitwidth`: 1 if value<=1, else ceil(log2)).
- `MVL`, 16: max vector length; `VW = bitwidth(MVL)`.
- `ADDRESS_WIDTH`, 10: memory address width.
- `DEPTH`, 2: number of pipeline stages, legal range 1..16; `CW = bitwidth(DEPTH+1)`.

- `clk_i` in 1: single clock, all state on rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `flush_i` in 1: synchronous pipeline flush.
- `in_valid_i` in 1: upstream beat valid.
- `in_ready_o` out 1: block accepts a beat this cycle.
- `add_i`, `sub_i`, `load_i`, `store_i` in 1 each: opcode one-hot.
- `src1_i`, `src2_i`, `dst_i` in RW each: register indices.
- `addr_i` in ADDRESS_WIDTH: memory address.
- `vector_length_reg_i` in VW: vector length.
- `out_valid_o` out 1: last stage holds a beat.
- `out_ready_i` in 1: downstream accepts.
- `add_o`, `sub_o`, `load_o`, `store_o`, `src1_o`, `src2_o`, `dst_o`, `addr_o`, `vector_length_reg_o` out: payload of last stage, same widths as inputs.
- `occupancy_o` out CW: number of valid stages.
- `illegal_o` out 1: one-cycle pulse, an illegal beat was dropped.

## Operation
- Stage k (0..DEPTH-1) holds valid bit `v[k]` plus full payload; stage DEPTH-1 drives all `*_o` payload outputs directly (registered outputs).
- Advance: `adv[DEPTH-1] = v[DEPTH-1] & out_ready_i`; `adv[k] = v[k] & (!v[k+1] | adv[k+1])`. Stage k loads from k-1 when k empty or advancing (bubbles collapse).
- `in_ready_o = !flush_i & (!v[0] | adv[0])` (combinational from `out_ready_i` chain).
- Accept = `in_valid_i & in_ready_o`. Beat is legal iff exactly one of add/sub/load/store set. Legal accepted beat sets `v[0]`; illegal accepted beat is consumed (handshake completes) but not inserted; `illegal_o` = 1 the following cycle.
- Stage payload registers load only when that stage captures; a held stage keeps its payload bit-exact.
- `occupancy_o` registered counter: +1 on legal insert, -1 on output handshake, both same cycle -> unchanged. Always equals popcount of `v`.
- `flush_i`: next edge clears every `v[k]`, `occupancy_o` -> 0, `illegal_o` -> 0; input in flush cycle not accepted; output handshake in flush cycle still counts as delivered downstream. Payload registers not cleared.
- Reset (async, any time, mid-transfer included): all `v` = 0, all payload outputs 0, `out_valid_o` 0, `occupancy_o` 0, `illegal_o` 0. `in_ready_o` = 1 during/after reset unless `flush_i`.

## Timing
- Latency: beat accepted at edge t appears on `out_valid_o`/payload after edge t+DEPTH-1 when downstream never stalls (DEPTH=2: visible one cycle after capture cycle, identical to old retarder).
- Throughput: 1 beat/cycle with `out_ready_i` high; full pipeline with `out_ready_i` low holds DEPTH beats, `in_ready_o` = 0.
- Full pipe and `out_ready_i` rising: `in_ready_o` rises in same cycle (no bubble).
- AXI-style rules: `out_valid_o` never drops and payload never changes while `!out_ready_i`, except on flush/reset. Upstream may not depend on `in_ready_o` to assert `in_valid_i`.
- `illegal_o` asserts exactly one cycle after the illegal accept edge.

## Test plan
- DEPTH=2, `out_ready_i`=1, stream add(src1=1,src2=2,dst=3,addr=0x055,vl=8) then sub then load each cycle -> each appears 1 cycle after capture cycle in order, `occupancy_o` steady at 2.
- DEPTH=4, `out_ready_i`=0, push 5 beats -> first 4 accepted, `in_ready_o`=0 on 5th, `occupancy_o`=4; raise `out_ready_i` -> 5th accepted same cycle, outputs drain in order with no gaps.
- Insert beat with add=1,sub=1 then beat with no op bits -> both handshakes complete, `illegal_o` pulses twice, neither reaches output, `occupancy_o` unchanged.
- Random valid/ready toggling, DEPTH=3, 1000 beats -> scoreboard matches order/payload, no drops or duplicates, payload stable while stalled.
- Full pipe of 3 beats, `flush_i` one cycle with `in_valid_i`=1 -> next cycle `out_valid_o`=0, `occupancy_o`=0, input beat not taken.
- Assert `rst_i` between edges mid-stream -> outputs go to 0 immediately without clock edge; after deassert, first beat has normal latency.
